// File: rtl/execute_stage_mc_if.sv
// Execute-stage boundary: decode-side E fields and hazard controls in, ALU/condition
// results and the E->M pipeline register out.
interface execute_stage_mc_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        E_stat;
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valC;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [3:0]        E_dstE;
    logic [3:0]        E_dstM;
    logic              setcc;
    logic              M_bubble;
    logic              E_stall;

    logic              e_busy;
    logic              e_cnd;
    logic [DATA_W-1:0] e_valE;
    logic [3:0]        e_dstE;
    logic [2:0]        cc;

    logic [3:0]        M_stat;
    logic [3:0]        M_icode;
    logic              M_cnd;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               setcc, M_bubble, E_stall,
        input  e_busy, e_cnd, e_valE, e_dstE, cc,
               M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               setcc, M_bubble, E_stall,
        output e_busy, e_cnd, e_valE, e_dstE, cc,
               M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_stage_mc.sv
// Y86 execute stage: ALU, condition codes, jXX/cmovXX evaluation, E->M register and a
// sequential signed multiplier (mulq) that stalls the front end while it iterates.
//
//   state  | meaning
//   IDLE   | no multiply in flight; a qualifying mulq in E starts one
//   BUSY   | retiring MUL_BPC multiplier bits per cycle, M receives bubbles
//   DONE   | product valid on e_valE; held here while E is stalled
module execute_stage_mc #(
    parameter int         DATA_W     = 64,
    parameter int         MUL_BPC    = 8,
    parameter int         STACK_STEP = DATA_W / 8,
    parameter logic [3:0] STAT_AOK   = 4'b1000
) (
    input logic               clk,
    input logic               rst_n,
    execute_stage_mc_if.slave bus
);
    localparam int K     = DATA_W / MUL_BPC;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int ACC_W = 2 * DATA_W;
    localparam int SUM_W = DATA_W + MUL_BPC;

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [ACC_W-1:0]  r_acc;
    logic              r_neg;
    logic              r_done_taken;
    logic [2:0]        r_cc;

    logic [3:0]        r_m_stat;
    logic [3:0]        r_m_icode;
    logic              r_m_cnd;
    logic [DATA_W-1:0] r_m_val_e;
    logic [DATA_W-1:0] r_m_val_a;
    logic [3:0]        r_m_dst_e;
    logic [3:0]        r_m_dst_m;

    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_m_bubble;
    logic              w_cc_we;
    logic              w_cnd;
    logic              w_of;
    logic              w_mul_of;
    logic [DATA_W-1:0] w_val_e;
    logic [DATA_W-1:0] w_add;
    logic [DATA_W-1:0] w_sub;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [SUM_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_prod;
    logic [DATA_W:0]   w_prod_top;
    logic              w_of_f;
    logic              w_sf_f;
    logic              w_zf_f;

    assign w_of_f = r_cc[2];
    assign w_sf_f = r_cc[1];
    assign w_zf_f = r_cc[0];

    assign w_is_mul    = (bus.E_icode == I_OP) && (bus.E_ifun == 4'h4);
    assign w_mul_start = (r_state == S_IDLE) && w_is_mul &&
                         (bus.E_stat == STAT_AOK) && !bus.M_bubble;

    // A DONE cycle that has already handed its product to M must not hand it again.
    assign w_m_bubble = bus.M_bubble || (r_state == S_BUSY) || w_mul_start ||
                        ((r_state == S_DONE) && r_done_taken);
    assign w_cc_we    = !w_m_bubble && (bus.E_icode == I_OP) && bus.setcc &&
                        (bus.E_stat == STAT_AOK);

    assign w_add = bus.E_valB + bus.E_valA;
    assign w_sub = bus.E_valB - bus.E_valA;

    assign w_abs_a = bus.E_valA[DATA_W-1] ? (~bus.E_valA + DATA_W'(1)) : bus.E_valA;
    assign w_abs_b = bus.E_valB[DATA_W-1] ? (~bus.E_valB + DATA_W'(1)) : bus.E_valB;

    // Radix-2^MUL_BPC shift-add: low half holds the unconsumed multiplier digits,
    // high half accumulates; the pair shifts right one digit per step.
    assign w_sum      = SUM_W'(r_acc[ACC_W-1:DATA_W]) +
                        SUM_W'(r_mcand) * SUM_W'(r_acc[MUL_BPC-1:0]);
    assign w_acc_next = ACC_W'({w_sum, r_acc[DATA_W-1:0]} >> MUL_BPC);

    assign w_prod     = r_neg ? (~r_acc + ACC_W'(1)) : r_acc;
    assign w_prod_top = w_prod[ACC_W-1:DATA_W-1];
    assign w_mul_of   = !((&w_prod_top) || !(|w_prod_top));

    always_comb begin
        w_cnd = 1'b0;
        if ((bus.E_icode == I_CMOV) || (bus.E_icode == I_JXX)) begin
            case (bus.E_ifun)
                4'h0:    w_cnd = 1'b1;
                4'h1:    w_cnd = (w_sf_f ^ w_of_f) | w_zf_f;
                4'h2:    w_cnd = w_sf_f ^ w_of_f;
                4'h3:    w_cnd = w_zf_f;
                4'h4:    w_cnd = !w_zf_f;
                4'h5:    w_cnd = !(w_sf_f ^ w_of_f);
                4'h6:    w_cnd = !(w_sf_f ^ w_of_f) && !w_zf_f;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_val_e = '0;
        w_of    = 1'b0;
        case (bus.E_icode)
            I_CMOV:           w_val_e = bus.E_valA;
            I_IRMOV:          w_val_e = bus.E_valC;
            I_RMMOV, I_MRMOV: w_val_e = bus.E_valC + bus.E_valB;
            I_OP: begin
                case (bus.E_ifun)
                    4'h0: begin
                        w_val_e = w_add;
                        w_of    = (bus.E_valA[DATA_W-1] == bus.E_valB[DATA_W-1]) &&
                                  (w_add[DATA_W-1] != bus.E_valA[DATA_W-1]);
                    end
                    4'h1: begin
                        w_val_e = w_sub;
                        w_of    = (bus.E_valA[DATA_W-1] != bus.E_valB[DATA_W-1]) &&
                                  (w_sub[DATA_W-1] != bus.E_valB[DATA_W-1]);
                    end
                    4'h2: w_val_e = bus.E_valB & bus.E_valA;
                    4'h3: w_val_e = bus.E_valB ^ bus.E_valA;
                    4'h4: begin
                        if (r_state == S_DONE) begin
                            w_val_e = w_prod[DATA_W-1:0];
                            w_of    = w_mul_of;
                        end
                    end
                    default: w_val_e = '0;
                endcase
            end
            I_CALL, I_PUSH:   w_val_e = bus.E_valB - DATA_W'(STACK_STEP);
            I_RET, I_POP:     w_val_e = bus.E_valB + DATA_W'(STACK_STEP);
            default:          w_val_e = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_neg        <= 1'b0;
            r_done_taken <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_start) begin
                        r_mcand      <= w_abs_a;
                        r_acc        <= ACC_W'(w_abs_b);
                        r_neg        <= bus.E_valA[DATA_W-1] ^ bus.E_valB[DATA_W-1];
                        r_cnt        <= '0;
                        r_done_taken <= 1'b0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.M_bubble) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == CNT_W'(K - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (bus.M_bubble || !bus.E_stall) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_done_taken <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_stat  <= STAT_AOK;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_val_e <= '0;
            r_m_val_a <= '0;
            r_m_dst_e <= REG_NONE;
            r_m_dst_m <= REG_NONE;
            r_cc      <= 3'b001;
        end else begin
            if (w_m_bubble) begin
                r_m_stat  <= STAT_AOK;
                r_m_icode <= I_NOP;
                r_m_cnd   <= 1'b0;
                r_m_val_e <= '0;
                r_m_val_a <= '0;
                r_m_dst_e <= REG_NONE;
                r_m_dst_m <= REG_NONE;
            end else begin
                r_m_stat  <= bus.E_stat;
                r_m_icode <= bus.E_icode;
                r_m_cnd   <= w_cnd;
                r_m_val_e <= w_val_e;
                r_m_val_a <= bus.E_valA;
                r_m_dst_e <= bus.e_dstE;
                r_m_dst_m <= bus.E_dstM;
            end
            if (w_cc_we) begin
                r_cc <= {w_of, w_val_e[DATA_W-1], (w_val_e == '0)};
            end
        end
    end

    assign bus.e_busy  = w_mul_start || (r_state == S_BUSY);
    assign bus.e_cnd   = w_cnd;
    assign bus.e_valE  = w_val_e;
    assign bus.e_dstE  = ((bus.E_icode == I_CMOV) && !w_cnd) ? REG_NONE : bus.E_dstE;
    assign bus.cc      = r_cc;
    assign bus.M_stat  = r_m_stat;
    assign bus.M_icode = r_m_icode;
    assign bus.M_cnd   = r_m_cnd;
    assign bus.M_valE  = r_m_val_e;
    assign bus.M_valA  = r_m_val_a;
    assign bus.M_dstE  = r_m_dst_e;
    assign bus.M_dstM  = r_m_dst_m;
endmodule
